shift_reg_p: RTL and testbench

SHIFT_REG_P -- requirements
Module: shift_reg_p

---
 rtl/shift_reg_pkg.sv | 16 +
 rtl/shift_reg_if.sv | 24 ++
 rtl/shift_reg_step.sv | 43 ++++
 rtl/shift_reg_p.sv | 130 +++++++++++++
 tb/tb_shift_reg_p.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types for the burst shift register: shift modes and FSM states.
package shift_reg_pkg;

    typedef enum logic [1:0] {
        SH_LOGIC = 2'b00,
        SH_ROT   = 2'b01,
        SH_ARITH = 2'b10,
        SH_HOLD  = 2'b11
    } sh_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sh_state_t;

endpackage

// File: rtl/shift_reg_if.sv
// Signal bundle for driving and observing shift_reg_p from a bench.
interface shift_reg_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] datain;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [1:0]       mode;
    logic             direction;
    logic             serial_in;
    logic [WIDTH-1:0] dataout;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport drv (
        output clk, reset, load, datain, start, count, mode, direction, serial_in,
        input  dataout, serial_out, busy, done
    );
endinterface

// File: rtl/shift_reg_step.sv
// Single-step shift transform: one bit position in the selected mode/direction.
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  sh_mode_t         mode,
    input  logic             direction,
    input  logic             fill,
    output logic [WIDTH-1:0] next_data,
    output logic             out_bit
);

    // Compute the shifted word and the bit that falls off the end.
    always_comb begin
        next_data = data;
        out_bit   = 1'b0;
        case (mode)
            SH_LOGIC: begin
                out_bit   = direction ? data[WIDTH-1] : data[0];
                next_data = direction ? {data[WIDTH-2:0], fill}
                                      : {fill, data[WIDTH-1:1]};
            end
            SH_ROT: begin
                out_bit   = direction ? data[WIDTH-1] : data[0];
                next_data = direction ? {data[WIDTH-2:0], data[WIDTH-1]}
                                      : {data[0], data[WIDTH-1:1]};
            end
            SH_ARITH: begin
                out_bit   = direction ? data[WIDTH-1] : data[0];
                next_data = direction ? {data[WIDTH-2:0], 1'b0}
                                      : {data[WIDTH-1], data[WIDTH-1:1]};
            end
            default: begin
                // Hold: word unchanged, nothing shifted out.
                next_data = data;
                out_bit   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/shift_reg_p.sv
// Parallel-load shift register that runs counted single-bit shift bursts.
module shift_reg_p
    import shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] datain,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       mode,
    input  logic             direction,
    input  logic             serial_in,
    output logic [WIDTH-1:0] dataout,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    sh_state_t        state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    sh_mode_t         mode_q, mode_d;
    logic             dir_q, dir_d;

    logic [WIDTH-1:0] step_data;
    logic             step_bit;
    logic             last_step;

    assign last_step = (cnt_q == CNT_W'(1));

    shift_reg_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data      (data_q),
        .mode      (mode_q),
        .direction (dir_q),
        .fill      (serial_in),
        .next_data (step_data),
        .out_bit   (step_bit)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: leave IDLE only on an accepted non-empty burst.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!load && start && (count != '0)) state_d = SHIFT;
            SHIFT:   if (last_step) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and status next values; load beats start, both ignored mid-burst.
    always_comb begin
        data_d = data_q;
        sout_d = sout_q;
        busy_d = busy_q;
        done_d = 1'b0;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        case (state_q)
            IDLE: begin
                if (load) begin
                    data_d = datain;
                end else if (start) begin
                    if (count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d  = count;
                        mode_d = sh_mode_t'(mode);
                        dir_d  = direction;
                        busy_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                data_d = step_data;
                sout_d = step_bit;
                cnt_d  = cnt_q - CNT_W'(1);
                if (last_step) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q <= '0;
            sout_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            mode_q <= SH_LOGIC;
            dir_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            sout_q <= sout_d;
            busy_q <= busy_d;
            done_q <= done_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
        end
    end

    assign dataout    = data_q;
    assign serial_out = sout_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_shift_reg_p.sv
// Scoreboard bench for shift_reg_p at WIDTH=8, CNT_W=4.
module tb_shift_reg_p;

    typedef struct packed {
        logic [7:0] data;
        logic       sout;
        logic       busy;
        logic       done;
    } exp_t;

    shift_reg_if #(.WIDTH(8), .CNT_W(4)) sif ();

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];

    shift_reg_p #(
        .WIDTH (8),
        .CNT_W (4)
    ) dut (
        .clk        (sif.clk),
        .reset      (sif.reset),
        .load       (sif.load),
        .datain     (sif.datain),
        .start      (sif.start),
        .count      (sif.count),
        .mode       (sif.mode),
        .direction  (sif.direction),
        .serial_in  (sif.serial_in),
        .dataout    (sif.dataout),
        .serial_out (sif.serial_out),
        .busy       (sif.busy),
        .done       (sif.done)
    );

    initial sif.clk = 1'b0;
    always #5 sif.clk = ~sif.clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic so, input logic b, input logic dn);
        exp_t e;
        e.data = d; e.sout = so; e.busy = b; e.done = dn;
        exp_q.push_back(e);
    endtask

    // Advance one edge and compare the DUT against the oldest expectation.
    task automatic tick();
        exp_t e;
        @(posedge sif.clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("dataout",    64'(sif.dataout),    64'(e.data));
            check_eq("serial_out", 64'(sif.serial_out), 64'(e.sout));
            check_eq("busy",       64'(sif.busy),       64'(e.busy));
            check_eq("done",       64'(sif.done),       64'(e.done));
        end
    endtask

    task automatic idle_inputs();
        sif.load = 1'b0; sif.start = 1'b0; sif.datain = 8'h00; sif.count = 4'd0;
        sif.mode = 2'b00; sif.direction = 1'b0; sif.serial_in = 1'b0;
    endtask

    logic [7:0] rot_seq [8];
    logic       rot_out [8];

    initial begin
        rot_seq = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        rot_out = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        idle_inputs();
        sif.reset = 1'b1;
        #1 sif.reset = 1'b0;
        #1;
        check_eq("rst_data", 64'(sif.dataout), 64'h0);
        check_eq("rst_sout", 64'(sif.serial_out), 64'h0);
        check_eq("rst_busy", 64'(sif.busy), 64'h0);
        check_eq("rst_done", 64'(sif.done), 64'h0);
        #10 sif.reset = 1'b1;

        // Logical left, fill 1.
        sif.load = 1'b1; sif.datain = 8'hA5; push(8'hA5, 0, 0, 0); tick();
        idle_inputs();
        sif.start = 1'b1; sif.count = 4'd3; sif.mode = 2'b00; sif.direction = 1'b1; sif.serial_in = 1'b1;
        push(8'hA5, 0, 1, 0); tick();
        sif.start = 1'b0;
        push(8'h4B, 1, 1, 0); tick();
        push(8'h97, 0, 1, 0); tick();
        push(8'h2F, 1, 0, 1); tick();
        push(8'h2F, 1, 0, 0); tick();

        // Arithmetic right.
        idle_inputs();
        sif.load = 1'b1; sif.datain = 8'h90; push(8'h90, 1, 0, 0); tick();
        idle_inputs();
        sif.start = 1'b1; sif.count = 4'd2; sif.mode = 2'b10; sif.direction = 1'b0; sif.serial_in = 1'b1;
        push(8'h90, 1, 1, 0); tick();
        sif.start = 1'b0;
        push(8'hC8, 0, 1, 0); tick();
        push(8'hE4, 0, 0, 1); tick();
        push(8'hE4, 0, 0, 0); tick();

        // Rotate right by full width returns the original word.
        idle_inputs();
        sif.load = 1'b1; sif.datain = 8'h81; push(8'h81, 0, 0, 0); tick();
        idle_inputs();
        sif.start = 1'b1; sif.count = 4'd8; sif.mode = 2'b01; sif.direction = 1'b0;
        push(8'h81, 0, 1, 0); tick();
        sif.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sif.serial_in = 1'($urandom_range(1));
            push(rot_seq[i], rot_out[i], (i != 7), (i == 7));
            tick();
        end
        push(8'h81, 1, 0, 0); tick();

        // Zero-count start, then load and start together.
        idle_inputs();
        sif.load = 1'b1; sif.datain = 8'h3C; push(8'h3C, 1, 0, 0); tick();
        idle_inputs();
        sif.start = 1'b1; sif.count = 4'd0; sif.mode = 2'b01;
        push(8'h3C, 1, 0, 1); tick();
        idle_inputs();
        push(8'h3C, 1, 0, 0); tick();
        sif.load = 1'b1; sif.datain = 8'h5A; sif.start = 1'b1; sif.count = 4'd3; sif.mode = 2'b01;
        push(8'h5A, 1, 0, 0); tick();
        idle_inputs();
        push(8'h5A, 1, 0, 0); tick();
        push(8'h5A, 1, 0, 0); tick();

        // Load and start asserted mid-burst are ignored.
        sif.load = 1'b1; sif.datain = 8'h0F; push(8'h0F, 1, 0, 0); tick();
        idle_inputs();
        sif.start = 1'b1; sif.count = 4'd2; sif.mode = 2'b00; sif.direction = 1'b0; sif.serial_in = 1'b0;
        push(8'h0F, 1, 1, 0); tick();
        sif.load = 1'b1; sif.datain = 8'h00; sif.start = 1'b1; sif.count = 4'd7;
        push(8'h07, 1, 1, 0); tick();
        push(8'h03, 1, 0, 1); tick();
        idle_inputs();
        push(8'h03, 1, 0, 0); tick();

        // Hold mode steps count but leave the word alone.
        sif.start = 1'b1; sif.count = 4'd2; sif.mode = 2'b11; sif.direction = 1'b1; sif.serial_in = 1'b1;
        push(8'h03, 1, 1, 0); tick();
        sif.start = 1'b0;
        push(8'h03, 0, 1, 0); tick();
        push(8'h03, 0, 0, 1); tick();
        push(8'h03, 0, 0, 0); tick();

        // Reset mid-burst, then load on the first edge after release.
        idle_inputs();
        sif.start = 1'b1; sif.count = 4'd5; sif.mode = 2'b00; sif.direction = 1'b1; sif.serial_in = 1'b0;
        push(8'h03, 0, 1, 0); tick();
        sif.start = 1'b0;
        push(8'h06, 0, 1, 0); tick();
        push(8'h0C, 0, 1, 0); tick();
        #2 sif.reset = 1'b0;
        #1;
        check_eq("mid_rst_data", 64'(sif.dataout), 64'h0);
        check_eq("mid_rst_sout", 64'(sif.serial_out), 64'h0);
        check_eq("mid_rst_busy", 64'(sif.busy), 64'h0);
        check_eq("mid_rst_done", 64'(sif.done), 64'h0);
        push(8'h00, 0, 0, 0); tick();
        #2;
        sif.reset = 1'b1;
        sif.load = 1'b1; sif.datain = 8'hFF;
        push(8'hFF, 0, 0, 0); tick();
        idle_inputs();
        push(8'hFF, 0, 0, 0); tick();

        check_eq("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
